// File: rtl/codificador_pkg.sv
// Shared types and widths for the 4-to-2 priority encoder with synchronized
// request inputs and a valid/ready handshake.
package codificador_pkg;

    localparam int REQ_W  = 4;
    localparam int CODE_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : codificador_pkg

// File: rtl/sincronizador_ff.sv
// Single-bit multi-flop synchronizer for bringing an asynchronous level into
// the clk domain; all stages clear on the asynchronous active-low reset.
module sincronizador_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages_r;

    // Shift the sampled level through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages_r <= {DEPTH{1'b0}};
        end else begin
            stages_r <= {stages_r[DEPTH-2:0], d};
        end
    end

    assign q = stages_r[DEPTH-1];

endmodule : sincronizador_ff

// File: rtl/codificador_prioridade_4x2.sv
// Captures rising edges on four asynchronous request lines into a pending
// vector and hands them out highest-first, one per valid/ready handshake.
module codificador_prioridade_4x2
    import codificador_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQ_W-1:0]  req,
    input  logic              ready,
    input  logic              clr_ovf,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [REQ_W-1:0]  pend,
    output logic              ovf
);

    logic [REQ_W-1:0]  sync_s;
    logic [REQ_W-1:0]  prev_r;
    logic [REQ_W-1:0]  rise_s;
    logic [REQ_W-1:0]  pend_r;
    logic [REQ_W-1:0]  pend_next_s;
    logic [REQ_W-1:0]  clr_mask_s;
    logic [CODE_W-1:0] code_r;
    logic [CODE_W-1:0] code_next_s;
    logic [CODE_W-1:0] grant_code_s;
    logic              grant_s;
    logic              lost_s;
    logic              valid_r;
    logic              valid_next_s;
    logic              ovf_r;
    logic              ovf_next_s;
    state_t            state_r;
    state_t            next_state_s;

    // Highest set bit wins; bit 3 maps to code 11
    function automatic logic [CODE_W-1:0] prio_encode(input logic [REQ_W-1:0] vec);
        logic [CODE_W-1:0] idx;
        if (vec[3]) begin
            idx = 2'd3;
        end else if (vec[2]) begin
            idx = 2'd2;
        end else if (vec[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    for (genvar i = 0; i < REQ_W; i++) begin : g_sync
        sincronizador_ff #(
            .DEPTH (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (req[i]),
            .q     (sync_s[i])
        );
    end

    // prev resets to 0 so a line already high at reset release counts once
    assign rise_s = sync_s & ~prev_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic for the grant handshake
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|pend_r) begin
                    next_state_s = HOLD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HOLD: begin
                if (ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Grant selection, pending-vector update and overflow detection
    always_comb begin
        grant_s      = (state_r == IDLE) && (|pend_r);
        grant_code_s = prio_encode(pend_r);
        if (grant_s) begin
            clr_mask_s  = {{(REQ_W-1){1'b0}}, 1'b1} << grant_code_s;
            code_next_s = grant_code_s;
        end else begin
            clr_mask_s  = {REQ_W{1'b0}};
            code_next_s = code_r;
        end
        // A new rise on a bit being granted this cycle re-arms it instead of overflowing
        pend_next_s  = (pend_r & ~clr_mask_s) | rise_s;
        lost_s       = |(rise_s & pend_r & ~clr_mask_s);
        valid_next_s = (next_state_s == HOLD);
        if (lost_s) begin
            ovf_next_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Datapath registers feeding the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r  <= {REQ_W{1'b0}};
            pend_r  <= {REQ_W{1'b0}};
            code_r  <= {CODE_W{1'b0}};
            valid_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            prev_r  <= sync_s;
            pend_r  <= pend_next_s;
            code_r  <= code_next_s;
            valid_r <= valid_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    assign code  = code_r;
    assign valid = valid_r;
    assign pend  = pend_r;
    assign ovf   = ovf_r;

endmodule : codificador_prioridade_4x2
